heatmap_vga_painter: RTL and testbench



---
 rtl/heatmap_vga_painter.sv | 114 +++++++++++
 tb/tb_heatmap_vga_painter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/heatmap_vga_painter.sv
// heatmap_vga_painter: reads one RAM row of colours and paints it as a scrolling strip of cells into the VGA buffer.
// Define HEATMAP_GRID_LINES_EN to draw black grid lines on the right column and bottom row of every cell.
module heatmap_vga_painter #(
  parameter int N_COLS = 64,
  parameter int CELL_W = 8,
  parameter int CELL_H = 4,
  parameter int N_ROWS = 64,
  parameter int X_OFF  = 64,
  parameter int Y_OFF  = 16
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       done_write_sig,
  output logic       comp_allow,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic [9:0] vga_x,
  output logic [9:0] vga_y,
  output logic [7:0] vga_color,
  output logic       vga_we,
  output logic       busy,
  output logic [7:0] row_idx
);
  localparam int PW = CELL_W > 1 ? $clog2(CELL_W) : 1;
  localparam int HW = CELL_H > 1 ? $clog2(CELL_H) : 1;
  typedef enum logic [2:0] {REQ, WAIT_DONE, ADDR, WAIT, PAINT, NEXT_ROW} state_t;
  state_t state_q, state_d;
  logic [7:0] col_q, col_d, row_q, row_d, color_q, color_d, c_q, c_d, c_pix;
  logic [PW-1:0] px_q, px_d;
  logic [HW-1:0] py_q, py_d;
  logic [9:0] x_q, x_d, y_q, y_d, x_pix, y_pix;
  logic paint, px_end, py_end, col_end;
  assign paint   = state_q == PAINT;
  assign px_end  = px_q == PW'(CELL_W - 1);
  assign py_end  = py_q == HW'(CELL_H - 1);
  assign col_end = col_q == 8'(N_COLS - 1);
  assign x_pix   = 10'(X_OFF) + 10'(col_q) * 10'(CELL_W) + 10'(px_q);
  assign y_pix   = 10'(Y_OFF) + 10'(row_q) * 10'(CELL_H) + 10'(py_q);
`ifdef HEATMAP_GRID_LINES_EN
  assign c_pix = (px_end || py_end) ? 8'h00 : color_q;
`else
  assign c_pix = color_q;
`endif
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    color_d = color_q;
    px_d    = px_q;
    py_d    = py_q;
    x_d     = paint ? x_pix : x_q;
    y_d     = paint ? y_pix : y_q;
    c_d     = paint ? c_pix : c_q;
    case (state_q)
      REQ:       state_d = WAIT_DONE;
      WAIT_DONE: begin
        col_d   = done_write_sig ? 8'd0 : col_q;
        state_d = done_write_sig ? ADDR : WAIT_DONE;
      end
      ADDR:      state_d = WAIT;
      WAIT: begin
        color_d = rd_data;
        px_d    = '0;
        py_d    = '0;
        state_d = PAINT;
      end
      PAINT: begin
        px_d = px_end ? '0 : px_q + 1'b1;
        py_d = px_end ? (py_end ? '0 : py_q + 1'b1) : py_q;
        if (px_end && py_end) begin
          col_d   = col_end ? col_q : col_q + 8'd1;
          state_d = col_end ? NEXT_ROW : ADDR;
        end
      end
      NEXT_ROW: begin
        row_d   = row_q == 8'(N_ROWS - 1) ? 8'd0 : row_q + 8'd1;
        state_d = REQ;
      end
      default:   state_d = REQ;
    endcase
  end
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q <= REQ;
      col_q   <= '0;
      row_q   <= '0;
      color_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      color_q <= color_d;
      px_q    <= px_d;
      py_q    <= py_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
    end
  end
  // Pixel outputs are live during PAINT and otherwise hold the last painted pixel.
  assign vga_we     = paint;
  assign vga_x      = x_d;
  assign vga_y      = y_d;
  assign vga_color  = c_d;
  assign comp_allow = state_q == REQ && !reset;
  assign busy       = state_q != WAIT_DONE && !reset;
  assign rd_addr    = col_q;
  assign row_idx    = row_q;
endmodule

// File: tb/tb_heatmap_vga_painter.sv
// tb_heatmap_vga_painter: scoreboard bench; a wide instance checks pixel streams, a narrow one checks row wrap-around.
module tb_heatmap_vga_painter;
  logic clk_50 = 0, reset = 1, done = 0, done2 = 0, ram_const = 0;
  logic comp_allow, vga_we, busy, ca2, we2, busy2;
  logic [7:0] rd_addr, vga_color, row_idx, rd_addr2, c2, row2;
  logic [7:0] rd_data = 0, rd_data2 = 0;
  logic [9:0] vga_x, vga_y, x2, y2;
  typedef struct packed {logic [9:0] x; logic [9:0] y; logic [7:0] c;} pix_t;
  pix_t exp_q[$];
  pix_t e;
  int checks = 0, failures = 0, cyc = 0;
  int wr_cnt = 0, first_wr = 0, last_wr = 0, ca_cnt = 0, ca_cyc = 0;
  int w2 = 0, ca2_cnt = 0, y2min = 1023, y2max = 0;
  logic [9:0] last_x = 0, last_y = 0;
  logic [7:0] c2_last = 0;

  heatmap_vga_painter dut (
    .clk_50(clk_50), .reset(reset), .done_write_sig(done), .comp_allow(comp_allow),
    .rd_addr(rd_addr), .rd_data(rd_data), .vga_x(vga_x), .vga_y(vga_y),
    .vga_color(vga_color), .vga_we(vga_we), .busy(busy), .row_idx(row_idx)
  );
  heatmap_vga_painter #(.N_COLS(2)) dut2 (
    .clk_50(clk_50), .reset(reset), .done_write_sig(done2), .comp_allow(ca2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .vga_x(x2), .vga_y(y2),
    .vga_color(c2), .vga_we(we2), .busy(busy2), .row_idx(row2)
  );

  always #5 clk_50 = ~clk_50;

  // RAM models: data appears one cycle after the address
  always @(posedge clk_50) begin
    cyc      <= cyc + 1;
    rd_data  <= ram_const ? 8'hE0 : rd_addr;
    rd_data2 <= rd_addr2;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", n, a, x, cyc);
    end
  endtask

  function automatic logic [7:0] exp_c(input int px, input int py, input logic [7:0] d);
`ifdef HEATMAP_GRID_LINES_EN
    return (px == 7 || py == 3) ? 8'h00 : d;
`else
    return d;
`endif
  endfunction

  initial forever begin
    @(negedge clk_50);
    if (comp_allow) begin ca_cnt++; ca_cyc = cyc; end
    if (vga_we) begin
      if (wr_cnt == 0) first_wr = cyc;
      wr_cnt++;
      last_wr = cyc;
      last_x = vga_x;
      last_y = vga_y;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write got x=%0d y=%0d c=%0h want no write", vga_x, vga_y, vga_color);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", {vga_x, vga_y, vga_color}, e);
      end
    end
    if (ca2) ca2_cnt++;
    if (we2) begin
      w2++;
      c2_last = c2;
      if (int'(y2) < y2min) y2min = y2;
      if (int'(y2) > y2max) y2max = y2;
    end
  end

  task automatic push_row(input int r);
    pix_t p;
    for (int col = 0; col < 64; col++)
      for (int py = 0; py < 4; py++)
        for (int px = 0; px < 8; px++) begin
          p.x = 10'(64 + col * 8 + px);
          p.y = 10'(16 + r * 4 + py);
          p.c = exp_c(px, py, ram_const ? 8'hE0 : 8'(col));
          exp_q.push_back(p);
        end
  endtask

  task automatic do_row(input int r, input bit inj);
    int ca0, cd;
    push_row(r);
    wr_cnt = 0;
    ca0 = ca_cnt;
    @(posedge clk_50); #1 done = 1; cd = cyc;
    @(posedge clk_50); #1 done = 0;
    if (inj) begin
      repeat (3) begin
        repeat (300) @(posedge clk_50);
        #1 done = 1;
        @(posedge clk_50); #1 done = 0;
      end
      chk("inj_row_idx", row_idx, r);
    end
    for (int i = 0; i < 3000 && ca_cnt == ca0; i++) @(negedge clk_50);
    chk("row_comp_allow", ca_cnt - ca0, 1);
    chk("first_we_latency", first_wr - cd, 3);
    chk("write_count", wr_cnt, 2048);
    chk("comp_after_last", ca_cyc - last_wr, 2);
    chk("last_xy", {last_x, last_y}, {10'd575, 10'(16 + r * 4 + 3)});
    chk("queue_empty", exp_q.size(), 0);
    @(negedge clk_50);
    chk("idle_busy", busy, 0);
    chk("next_row_idx", row_idx, (r + 1) % 64);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    chk("reset_comp_allow", comp_allow, 0);
    chk("reset_busy", busy, 0);
    chk("reset_we", vga_we, 0);
    chk("reset_xy", {vga_x, vga_y}, 0);
    chk("reset_c_addr_row", {vga_color, rd_addr, row_idx}, 0);
    @(posedge clk_50); #1 reset = 0;
    @(negedge clk_50);
    chk("first_comp_allow", comp_allow, 1);
    chk("req_busy", busy, 1);
    @(negedge clk_50);
    chk("comp_allow_single", comp_allow, 0);
    chk("wait_busy", busy, 0);
    repeat (3) begin
      @(negedge clk_50);
      chk("wait_we", vga_we, 0);
    end
    chk("comp_allow_count", ca_cnt, 1);

    do_row(0, 0);
    do_row(1, 1);
    ram_const = 1;
    do_row(2, 0);
    ram_const = 0;

    // abort row 3 partway through with reset
    push_row(3);
    wr_cnt = 0;
    @(posedge clk_50); #1 done = 1;
    @(posedge clk_50); #1 done = 0;
    for (int i = 0; i < 2000 && wr_cnt < 1000; i++) @(negedge clk_50);
    #1 reset = 1;
    n = wr_cnt;
    chk("reset_point", n >= 1000, 1);
    @(negedge clk_50);
    chk("abort_we", vga_we, 0);
    chk("abort_comp_allow", comp_allow, 0);
    @(negedge clk_50);
    chk("abort_busy", busy, 0);
    exp_q.delete();
    @(negedge clk_50);
    chk("no_write_after_reset", wr_cnt, n);
    @(posedge clk_50); #1 reset = 0;
    @(negedge clk_50);
    chk("restart_comp_allow", comp_allow, 1);
    chk("restart_row_idx", row_idx, 0);
    do_row(0, 0);

    // narrow instance: 65 rows to cover the screen-row wrap
    for (int r = 0; r < 65; r++) begin
      int c0;
      for (int i = 0; i < 100 && busy2; i++) @(negedge clk_50);
      chk("wrap_idle", busy2, 0);
      if (r == 63) chk("wrap_row63_idx", row2, 63);
      if (r == 64) chk("wrap_row64_idx", row2, 0);
      y2min = 1023;
      y2max = 0;
      w2 = 0;
      c0 = ca2_cnt;
      @(posedge clk_50); #1 done2 = 1;
      @(posedge clk_50); #1 done2 = 0;
      for (int i = 0; i < 500 && ca2_cnt == c0; i++) @(negedge clk_50);
      if (ca2_cnt == c0) chk("wrap_row_timeout", r, 999);
      if (r == 0) chk("wrap_writes", w2, 64);
      if (r == 63) chk("wrap_row63_y", {y2min[9:0], y2max[9:0]}, {10'd268, 10'd271});
      if (r == 64) begin
        chk("wrap_row64_y", {y2min[9:0], y2max[9:0]}, {10'd16, 10'd19});
        chk("wrap_last_color", c2_last, exp_c(7, 3, 8'd1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
